// File: rtl/rvv_insn_feeder.sv
// rvv_insn_feeder: host-to-vector-core instruction buffer with drain/sync FSM.
// Host instructions enter a small FIFO over a valid/ready handshake.
// The FIFO presents them first-word-fall-through to the vector core.
// A sync request blocks new intake. It completes once the FIFO is empty and
// the core has reported idle for two consecutive cycles.
// Optional feature macro: RVV_FEEDER_OPCODE_FILTER_EN. When it is defined,
// instructions with an opcode other than OP-V, vector load or vector store
// are accepted from the host but are not written to the FIFO.
module rvv_insn_feeder #(
  parameter int unsigned INSN_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_WIDTH  = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  host_valid,
  input  logic [INSN_WIDTH-1:0] host_insn,
  output logic                  host_ready,
  output logic [INSN_WIDTH-1:0] insn_out,
  output logic                  insn_valid,
  input  logic                  insn_ready,
  input  logic                  rvv_idle,
  input  logic                  sync_req,
  output logic                  sync_busy,
  output logic                  sync_done,
  output logic [CNT_WIDTH-1:0]  fifo_count,
  output logic                  illegal_out
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                  state, state_next;
  logic [INSN_WIDTH-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [CNT_WIDTH-1:0]    count;
  logic [1:0]              idle_cnt;
  logic                    full, empty, push, pop, legal, wr_en, idle_qual;

  assign full  = (count == CNT_WIDTH'(FIFO_DEPTH));
  assign empty = (count == '0);

  // The state is IDLE while reset is held, so host_ready is also gated by rst
  // to keep it low during reset.
  assign host_ready = rst && !full && (state == IDLE);
  assign push       = host_valid && host_ready;
  assign insn_valid = !empty;
  assign pop        = insn_valid && insn_ready;
  assign wr_en      = push && legal;
  assign insn_out   = empty ? '0 : mem[rd_ptr];
  assign fifo_count = count;
  assign sync_busy  = (state == DRAIN);
  assign sync_done  = (state == DONE);
  assign idle_qual  = (state == DRAIN) && empty && rvv_idle;

`ifdef RVV_FEEDER_OPCODE_FILTER_EN
  logic illegal_q;

  assign legal = (host_insn[6:0] == 7'b1010111) ||
                 (host_insn[6:0] == 7'b0000111) ||
                 (host_insn[6:0] == 7'b0100111);

  // Report a dropped instruction one cycle after its handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) illegal_q <= 1'b0;
    else      illegal_q <= push && !legal;
  end

  assign illegal_out = illegal_q;
`else
  assign legal       = 1'b1;
  assign illegal_out = 1'b0;
`endif

  // Write the FIFO storage. It has no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= host_insn;
  end

  // Update the FIFO pointers and occupancy. The pointers wrap naturally
  // because the depth is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + CNT_WIDTH'(1);
        2'b01:   count <= count - CNT_WIDTH'(1);
        default: count <= count;
      endcase
    end
  end

  // Register the state and count consecutive empty-and-idle cycles while
  // draining.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      idle_cnt <= '0;
    end else begin
      state    <= state_next;
      idle_cnt <= idle_qual ? idle_cnt + 2'd1 : '0;
    end
  end

  // Compute the next drain state. DONE is entered on the edge where the
  // qualifier count reaches 2.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (sync_req) state_next = DRAIN;
      DRAIN:   if (idle_qual && idle_cnt == 2'd1) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rvv_insn_feeder.sv
// Directed bench for rvv_insn_feeder (default parameters: 32-bit, depth 4).
module tb_rvv_insn_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic        host_valid;
  logic [31:0] host_insn;
  logic        host_ready;
  logic [31:0] insn_out;
  logic        insn_valid;
  logic        insn_ready;
  logic        rvv_idle;
  logic        sync_req;
  logic        sync_busy;
  logic        sync_done;
  logic [2:0]  fifo_count;
  logic        illegal_out;

  int tests = 0;
  int fails = 0;

  rvv_insn_feeder #(
    .INSN_WIDTH(32),
    .FIFO_DEPTH(4),
    .CNT_WIDTH (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .host_valid (host_valid),
    .host_insn  (host_insn),
    .host_ready (host_ready),
    .insn_out   (insn_out),
    .insn_valid (insn_valid),
    .insn_ready (insn_ready),
    .rvv_idle   (rvv_idle),
    .sync_req   (sync_req),
    .sync_busy  (sync_busy),
    .sync_done  (sync_done),
    .fifo_count (fifo_count),
    .illegal_out(illegal_out)
  );

  always #5 clk = ~clk;

  // Advance one rising edge. Inputs are driven and outputs sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst        = 1'b0;
    host_valid = 1'b0;
    host_insn  = '0;
    insn_ready = 1'b0;
    rvv_idle   = 1'b1;
    sync_req   = 1'b0;

    // Reset state
    #3;
    check("rst_host_ready", 32'(host_ready), 0);
    check("rst_insn_valid", 32'(insn_valid), 0);
    check("rst_insn_out",   insn_out, 0);
    check("rst_count",      32'(fifo_count), 0);
    check("rst_busy",       32'(sync_busy), 0);
    check("rst_done",       32'(sync_done), 0);
    check("rst_illegal",    32'(illegal_out), 0);
    step(); step();
    rst = 1'b1;
    #1;
    check("post_rst_host_ready", 32'(host_ready), 1);

    // Two pushes with the core always ready
    insn_ready = 1'b1;
    host_valid = 1'b1;
    host_insn  = 32'h0000_0057;
    step();
    check("t1_out0",   insn_out, 32'h0000_0057);
    check("t1_valid0", 32'(insn_valid), 1);
    check("t1_count0", 32'(fifo_count), 1);
    host_insn = 32'h0010_0057;
    step();
    check("t1_out1",   insn_out, 32'h0010_0057);
    check("t1_count1", 32'(fifo_count), 1);
    host_valid = 1'b0;
    step();
    check("t1_count_end", 32'(fifo_count), 0);
    check("t1_valid_end", 32'(insn_valid), 0);
    check("t1_out_empty", insn_out, 0);

    // Fill with five offered instructions, then drain in order
    insn_ready = 1'b0;
    host_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      host_insn = 32'hA0 + 32'(i);
      step();
    end
    check("t2_full_count", 32'(fifo_count), 4);
    check("t2_full_ready", 32'(host_ready), 0);
    host_insn = 32'hA4;
    step();
    check("t2_fifth_rejected", 32'(fifo_count), 4);
    host_valid = 1'b0;
    insn_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t2_pop_order", insn_out, 32'hA0 + 32'(i));
      check("t2_host_ready", 32'(host_ready), (i == 0) ? 0 : 1);
      step();
    end
    check("t2_empty_count", 32'(fifo_count), 0);
    check("t2_no_fifth",    32'(insn_valid), 0);

    // Steady push+pop at occupancy 2, across pointer wrap
    insn_ready = 1'b0;
    host_valid = 1'b1;
    host_insn  = 32'hB0; step();
    host_insn  = 32'hB1; step();
    insn_ready = 1'b1;
    for (int j = 0; j < 12; j++) begin
      host_insn = 32'hB2 + 32'(j);
      check("t3_order", insn_out, 32'hB0 + 32'(j));
      check("t3_count", 32'(fifo_count), 2);
      step();
    end
    host_valid = 1'b0;
    check("t3_tail0", insn_out, 32'hBC); step();
    check("t3_tail1", insn_out, 32'hBD); step();
    check("t3_drained", 32'(fifo_count), 0);

    // Drain with a busy core
    insn_ready = 1'b0;
    rvv_idle   = 1'b0;
    host_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      host_insn = 32'hC0 + 32'(i);
      step();
    end
    host_valid = 1'b0;
    sync_req   = 1'b1; step(); sync_req = 1'b0;
    check("t4_busy",       32'(sync_busy), 1);
    check("t4_host_ready", 32'(host_ready), 0);
    sync_req   = 1'b1; step(); sync_req = 1'b0;
    check("t4_busy_ignore", 32'(sync_busy), 1);
    check("t4_no_done",     32'(sync_done), 0);
    insn_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("t4_drain_order", insn_out, 32'hC0 + 32'(i));
      step();
    end
    check("t4_empty", 32'(fifo_count), 0);
    step(); step();
    check("t4_wait_idle_busy", 32'(sync_busy), 1);
    check("t4_wait_idle_done", 32'(sync_done), 0);
    rvv_idle = 1'b1;
    step();
    check("t4_q1_done", 32'(sync_done), 0);
    step();
    check("t4_done_pulse", 32'(sync_done), 1);
    check("t4_done_busy",  32'(sync_busy), 0);
    step();
    check("t4_done_clear", 32'(sync_done), 0);
    check("t4_idle_ready", 32'(host_ready), 1);
    step(); step();
    check("t4_no_second_done", 32'(sync_done), 0);

    // Sync while already empty and idle: done three cycles after the request
    sync_req = 1'b1; step(); sync_req = 1'b0;
    check("t4b_busy", 32'(sync_busy), 1);
    step();
    check("t4b_done_early", 32'(sync_done), 0);
    step();
    check("t4b_done_3", 32'(sync_done), 1);
    step();

    // Asynchronous reset mid-drain with two entries
    insn_ready = 1'b0;
    rvv_idle   = 1'b0;
    host_valid = 1'b1;
    host_insn  = 32'hD0; step();
    host_insn  = 32'hD1; step();
    host_valid = 1'b0;
    sync_req   = 1'b1; step(); sync_req = 1'b0;
    check("t5_busy_before", 32'(sync_busy), 1);
    check("t5_count_before", 32'(fifo_count), 2);
    #2 rst = 1'b0;
    #1;
    check("t5_rst_count", 32'(fifo_count), 0);
    check("t5_rst_valid", 32'(insn_valid), 0);
    check("t5_rst_out",   insn_out, 0);
    check("t5_rst_busy",  32'(sync_busy), 0);
    check("t5_rst_ready", 32'(host_ready), 0);
    rvv_idle = 1'b1;
    step(); step(); step();
    check("t5_rst_no_done", 32'(sync_done), 0);
    rst = 1'b1;
    step();
    check("t5_post_busy",  32'(sync_busy), 0);
    check("t5_post_count", 32'(fifo_count), 0);
    check("t5_post_ready", 32'(host_ready), 1);

    // Opcode filter
    insn_ready = 1'b1;
    host_valid = 1'b1;
    host_insn  = 32'h0000_0013;
    step();
`ifdef RVV_FEEDER_OPCODE_FILTER_EN
    check("t6_illegal_pulse", 32'(illegal_out), 1);
    check("t6_not_written",   32'(fifo_count), 0);
    host_insn = 32'h0000_0057;
    step();
    check("t6_illegal_clear", 32'(illegal_out), 0);
    check("t6_legal_out",     insn_out, 32'h0000_0057);
    check("t6_legal_count",   32'(fifo_count), 1);
    host_valid = 1'b0;
    step();
    check("t6_final_count",   32'(fifo_count), 0);
`else
    check("t6_no_filter_illegal", 32'(illegal_out), 0);
    check("t6_no_filter_out",     insn_out, 32'h0000_0013);
    host_valid = 1'b0;
    step();
    check("t6_no_filter_count",   32'(fifo_count), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rvv_insn_feeder.md
Name: rvv_insn_feeder

Overview:
Instruction-side front end for the vector processor: the producer that drives the core's insn_in and consumes its rvv_idle status. It accepts instructions from the scalar host over a valid/ready handshake and buffers them in a small FIFO. It presents them to the vector core over a second valid/ready handshake. A sync (drain) request blocks new intake and reports completion once the buffer is empty and the vector core has gone idle.

Parameters:
INSN_WIDTH, 32, width of one instruction
FIFO_DEPTH, 4, buffer entries; power of two, >= 2
CNT_WIDTH, $clog2(FIFO_DEPTH)+1, occupancy counter width

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous reset, active-low (0 = reset)
host_valid  input  1  host presents an instruction
host_insn  input  INSN_WIDTH  instruction from host
host_ready  output  1  feeder can accept host_insn this cycle
insn_out  output  INSN_WIDTH  instruction to vector core insn_in
insn_valid  output  1  insn_out is valid
insn_ready  input  1  vector core accepts insn_out this cycle
rvv_idle  input  1  vector core idle status
sync_req  input  1  one-cycle pulse requesting a drain
sync_busy  output  1  drain in progress
sync_done  output  1  one-cycle pulse: drain complete
fifo_count  output  CNT_WIDTH  current occupancy
illegal_out  output  1  one-cycle pulse: rejected instruction (feature only)

Behaviour:
- Reset (rst=0, async): rd/wr pointers 0, fifo_count 0, state IDLE, all outputs 0 (host_ready 0 while rst=0), sync_done 0, illegal_out 0. Buffered contents are discarded. Reset mid-drain returns to IDLE with no sync_done.
- Push when host_valid && host_ready. host_ready = !full && state==IDLE (registered full; there is no bypass, so a full FIFO with a simultaneous pop still reports host_ready=0).
- Pop when insn_valid && insn_ready. insn_valid = !empty. insn_out = head entry, first-word fall-through; insn_out = 0 when empty.
- Latency: an instruction pushed at edge N is visible on insn_out/insn_valid after edge N (cycle N+1). There is no push-to-pop bypass; an empty FIFO never pops in the push cycle.
- Simultaneous push and pop (not full, not empty): fifo_count unchanged, both pointers advance.
- Pointers wrap modulo FIFO_DEPTH. fifo_count ranges 0..FIFO_DEPTH; full = (count==FIFO_DEPTH), empty = (count==0).
- Order is strict FIFO; no reordering or dropping, except the optional feature below.
- Drain FSM:
  IDLE: sync_req=1 -> DRAIN. A push in the same cycle as sync_req is still accepted.
  DRAIN: sync_busy=1, host_ready=0. The FIFO keeps issuing to the core. The idle qualifier counts consecutive cycles with empty && rvv_idle and resets to 0 otherwise. When the count reaches 2 (absorbs the core's one-cycle idle lag after accepting an insn) -> DONE.
  DONE: sync_done=1 for exactly one cycle, sync_busy=0 -> IDLE.
- sync_req in DRAIN or DONE is ignored (no queuing).
- sync_req while already empty with rvv_idle=1: sync_done asserts 3 cycles after the sync_req cycle.

Optional Feature:
RVV_FEEDER_OPCODE_FILTER_EN
- Defined: host_insn[6:0] is checked on push. Legal opcodes are 1010111 (OP-V), 0000111 (LOAD-FP/vector load) and 0100111 (STORE-FP/vector store).
  - Illegal insn: the handshake completes (host_ready unaffected) but the insn is not written. illegal_out pulses 1 for one cycle on the next cycle. fifo_count is unchanged.
- Undefined: no check; every accepted insn is written; illegal_out tied 0.

Test Plan:
- Reset then push 0x00000057, 0x00100057 with insn_ready=1 -> insn_out shows 0x00000057 one cycle after its push, then 0x00100057; fifo_count returns to 0.
- insn_ready=0, push 5 insns (DEPTH=4) -> 4 accepted, host_ready=0 with fifo_count=4. Set insn_ready=1 -> 4 pops in order; host_ready=1 once count<4.
- Steady push+pop every cycle at count=2 -> count stays 2; output order equals input order across pointer wrap (>=10 insns).
- Load 3 insns, rvv_idle=0, pulse sync_req -> host_ready=0, sync_busy=1. Drain FIFO, raise rvv_idle -> sync_done pulse 2 cycles after empty&&idle first holds; a second sync_req while busy is ignored.
- Assert rst=0 asynchronously mid-drain with 2 entries -> all outputs 0 immediately, no sync_done. After release, state IDLE, fifo_count 0.
- With RVV_FEEDER_OPCODE_FILTER_EN: push 0x00000013 then 0x00000057 -> illegal_out pulse for the first; only 0x00000057 appears on insn_out; fifo_count peaks at 1.
